axis_arb_frame_mux: RTL

// - Frame-level AXI4-Stream N:1 mux that consumes an external arbiter's grant.
// - Drives the arbiter's request/acknowledge and forwards the granted port's frames.
// - Holds each grant until the tlast beat is accepted.
// - Sits directly downstream of arbiter (PORTS matched; ARB_BLOCK=1, ARB_BLOCK_ACK=1).
// - Output is registered with a skid register for full throughput and timing isolation.
//

---
 rtl/axis_arb_frame_mux.sv | 118 +++++++++++
 1 files changed

// File: rtl/axis_arb_frame_mux.sv
// Frame-level AXI4-Stream N:1 mux driven by an external frame arbiter.
// The granted port's beats pass through a registered output stage with one skid slot.
module axis_arb_frame_mux #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [PORTS-1:0]              request,
  output logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS-1:0]              grant,
  input  logic                          grant_valid,
  input  logic [ID_WIDTH-1:0]           grant_encoded,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid
);

  localparam int BEAT_W = DATA_WIDTH + 1 + USER_WIDTH + ID_WIDTH;

  logic                  ready_int_q, ready_int_d;
  logic                  m_valid_q, m_valid_d;
  logic                  temp_valid_q, temp_valid_d;
  logic [BEAT_W-1:0]     m_beat_q, temp_beat_q;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [USER_WIDTH-1:0] sel_user_s;
  logic                  sel_last_s;
  logic                  in_valid_s;
  logic [BEAT_W-1:0]     sel_beat_s;
  logic                  store_out_s, store_temp_s, temp_to_out_s;

  assign request       = s_axis_tvalid;
  assign s_axis_tready = grant & {PORTS{grant_valid & ready_int_q}};
  assign acknowledge   = grant & s_axis_tvalid & s_axis_tready & s_axis_tlast;

  // AND-OR select of the granted port's beat
  always_comb begin
    sel_data_s = '0;
    sel_user_s = '0;
    sel_last_s = 1'b0;
    in_valid_s = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      sel_data_s = sel_data_s | ({DATA_WIDTH{grant_encoded == ID_WIDTH'(i)}} &
                                 s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]);
      sel_user_s = sel_user_s | ({USER_WIDTH{grant_encoded == ID_WIDTH'(i)}} &
                                 s_axis_tuser[i*USER_WIDTH +: USER_WIDTH]);
      sel_last_s = sel_last_s | ((grant_encoded == ID_WIDTH'(i)) & s_axis_tlast[i]);
      in_valid_s = in_valid_s | ((grant_encoded == ID_WIDTH'(i)) &
                                 s_axis_tvalid[i] & s_axis_tready[i]);
    end
  end

  assign sel_beat_s = {sel_data_s, sel_last_s, sel_user_s, grant_encoded};

  // Skid control: ready is registered, so one beat may land in temp after a stall
  always_comb begin
    m_valid_d     = m_valid_q;
    temp_valid_d  = temp_valid_q;
    store_out_s   = 1'b0;
    store_temp_s  = 1'b0;
    temp_to_out_s = 1'b0;
    ready_int_d   = m_axis_tready | (~temp_valid_q & (~m_valid_q | ~in_valid_s));
    if (ready_int_q) begin
      if (m_axis_tready | ~m_valid_q) begin
        m_valid_d   = in_valid_s;
        store_out_s = 1'b1;
      end else begin
        temp_valid_d = in_valid_s;
        store_temp_s = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_d     = temp_valid_q;
      temp_valid_d  = 1'b0;
      temp_to_out_s = 1'b1;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_int_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      temp_valid_q <= 1'b0;
    end else begin
      ready_int_q  <= ready_int_d;
      m_valid_q    <= m_valid_d;
      temp_valid_q <= temp_valid_d;
    end
  end

  // Beat payload registers; contents are don't-care while their valid is low
  always_ff @(posedge clk) begin
    if (store_out_s) begin
      m_beat_q <= sel_beat_s;
    end else if (temp_to_out_s) begin
      m_beat_q <= temp_beat_q;
    end
    if (store_temp_s) begin
      temp_beat_q <= sel_beat_s;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tid} = m_beat_q;

endmodule
